// File: rtl/io_console_pkg.sv
// Shared types and constants for the Z80 I/O-mapped console transmitter.
package io_console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned STAT_OVF       = 7;
    localparam int unsigned STAT_BUSY      = 6;
    localparam int unsigned STAT_FULL      = 5;
    localparam int unsigned STAT_EMPTY     = 4;
    localparam int unsigned STAT_COUNT_MSB = 3;
    localparam int unsigned STAT_COUNT_LSB = 0;

    localparam logic [7:0] DEF_DATA_PORT   = 8'hBB;
    localparam logic [7:0] DEF_STATUS_PORT = 8'hBC;

    // Assemble the status byte seen by software on an IN from the status port.
    function automatic logic [7:0] pack_status(input logic       ovf,
                                               input logic       busy,
                                               input logic       full,
                                               input logic       empty,
                                               input logic [3:0] count);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_OVF]   = ovf;
        s[STAT_BUSY]  = busy;
        s[STAT_FULL]  = full;
        s[STAT_EMPTY] = empty;
        s[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
        return s;
    endfunction

endpackage

// File: rtl/io_console_tx_if.sv
// Z80 I/O bus signals between the CPU side (master) and the console port (slave).
interface io_console_tx_if;
    logic [7:0] address;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;

    modport master (output address, iorq_n, rd_n, wr_n, dbus_in, input dbus_out);
    modport slave  (input address, iorq_n, rd_n, wr_n, dbus_in, output dbus_out);
endinterface

// File: rtl/io_console_fifo.sv
// Byte FIFO, depth 2**FIFO_AW; full/empty come from the occupancy count.
module io_console_fifo #(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic [FIFO_AW:0] count,
    output logic             full,
    output logic             empty
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (FIFO_AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_console_tx.sv
// Console transmitter: OUTs to the data port queue bytes that leave as 8N1 frames on tx.
module io_console_tx
    import io_console_pkg::*;
#(
    parameter logic [7:0]  DATA_PORT    = DEF_DATA_PORT,
    parameter logic [7:0]  STATUS_PORT  = DEF_STATUS_PORT,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    io_console_tx_if.slave    bus,
    output logic              tx,
    output logic              busy
);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              wsel;
    logic              wsel_q;
    logic              rsel;
    logic              rsel_q;
    logic              push;
    logic              pop;
    logic              overflow;
    logic              ovf_set;
    logic              ovf_clr;
    logic [7:0]        fifo_dout;
    logic [FIFO_AW:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [7:0]        shift;
    logic [7:0]        shift_nxt;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_nxt;
    logic              baud_done;
    logic              tx_nxt;

    // One push per OUT: only the first cycle of a held write strobe counts.
    assign wsel = ~bus.iorq_n & ~bus.wr_n & (bus.address == DATA_PORT);
    assign rsel = ~bus.iorq_n & ~bus.rd_n & (bus.address == STATUS_PORT);
    assign push = wsel & ~wsel_q;

    // Overflow stays set until the read that reported it has ended; a new drop wins.
    assign ovf_set = push & fifo_full & ~pop;
    assign ovf_clr = rsel_q & ~rsel;

    assign bus.dbus_out = rsel ? pack_status(overflow, busy, fifo_full, fifo_empty,
                                             4'(fifo_count))
                               : 8'h00;

    io_console_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (bus.dbus_in),
        .pop     (pop),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
            overflow <= 1'b0;
            state    <= IDLE;
            shift    <= 8'h00;
            bit_cnt  <= 3'd0;
            baud_cnt <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            wsel_q   <= wsel;
            rsel_q   <= rsel;
            overflow <= ovf_set | (overflow & ~ovf_clr);
            state    <= state_nxt;
            shift    <= shift_nxt;
            bit_cnt  <= bit_cnt_nxt;
            baud_cnt <= baud_nxt;
            tx       <= tx_nxt;
            busy     <= ~fifo_empty | (state != IDLE);
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);

    // Frame sequencer; tx is registered from the current state so it trails by one cycle.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        baud_nxt    = baud_cnt;
        pop         = 1'b0;
        tx_nxt      = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_nxt   = fifo_dout;
                    bit_cnt_nxt = 3'd0;
                    baud_nxt    = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                tx_nxt = shift[0];
                if (baud_done) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
